bsg_mesh_xy_router_node: RTL and testbench

// - 5-port dimension-ordered (X-then-Y) mesh router node, one per manycore mesh coordinate.
// - Ports P/W/E/N/S use the bsg_noc_pkg ordering P=0, W=1, E=2, N=3, S=4.
// - Tiles and IO routers are built from this node; neighbouring nodes are stitched W<->E and N<->S.
// - Uses valid/ready links, a small input FIFO per port and round-robin output arbitration.

---
 rtl/bsg_mesh_xy_router_node.sv | 165 ++++++++++++++++
 tb/tb_bsg_mesh_xy_router_node.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mesh_xy_router_node.sv
// 5-port X-then-Y mesh router node: input FIFOs, XY routing, round-robin outputs.
// Optional BSG_MESH_ROUTER_STATS_EN adds per-output transfer counters on pkt_count_o.
module bsg_mesh_xy_router_node #(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int data_width_p   = 32,
  parameter int fifo_els_p     = 2,
  localparam int pkt_width_lp  =
    data_width_p + y_cord_width_p + x_cord_width_p
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  input  logic [4:0]                   v_i,
  input  logic [4:0][pkt_width_lp-1:0] data_i,
  output logic [4:0]                   ready_o,
  output logic [4:0]                   v_o,
  output logic [4:0][pkt_width_lp-1:0] data_o,
  input  logic [4:0]                   ready_i
`ifdef BSG_MESH_ROUTER_STATS_EN
  ,
  output logic [4:0][31:0]             pkt_count_o
`endif
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

  typedef logic [ptr_w_lp-1:0] ptr_t;
  typedef logic [cnt_w_lp-1:0] cnt_t;

  localparam int P = 0;
  localparam int W = 1;
  localparam int E = 2;
  localparam int N = 3;
  localparam int S = 4;

  logic [pkt_width_lp-1:0] mem_r [5][fifo_els_p];
  ptr_t [4:0] rd_ptr_r;
  ptr_t [4:0] wr_ptr_r;
  cnt_t [4:0] cnt_r;
  logic [4:0] enq;
  logic [4:0] deq;
  logic [4:0] xfer;
  logic [4:0][pkt_width_lp-1:0] head;
  logic [4:0][2:0] dir;
  logic [4:0][4:0] req;
  logic [4:0][2:0] gnt;
  logic [4:0][2:0] last_r;

  function automatic ptr_t nxt(ptr_t x);
    return (x == ptr_t'(fifo_els_p - 1)) ? '0 : x + 1'b1;
  endfunction

  // FIFO status, heads, and XY route of each head
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      ready_o[p] = (cnt_r[p] != cnt_t'(fifo_els_p));
      head[p]    = mem_r[p][rd_ptr_r[p]];
      priority case (1'b1)
        head[p][0 +: x_cord_width_p] < my_x_i: dir[p] = 3'(W);
        head[p][0 +: x_cord_width_p] > my_x_i: dir[p] = 3'(E);
        head[p][x_cord_width_p +: y_cord_width_p] < my_y_i:
          dir[p] = 3'(N);
        head[p][x_cord_width_p +: y_cord_width_p] > my_y_i:
          dir[p] = 3'(S);
        default: dir[p] = 3'(P);
      endcase
    end
  end

  assign enq = v_i & ready_o;
  assign xfer = v_o & ready_i;

  // Request matrix: req[q][p] when input p's head heads to output q
  always_comb begin
    for (int q = 0; q < 5; q++) begin
      for (int p = 0; p < 5; p++) begin
        req[q][p] = (cnt_r[p] != '0) && (dir[p] == 3'(q));
      end
    end
  end

  // Round-robin grant per output, starting after the last winner
  always_comb begin
    logic found;
    logic [3:0] idx;
    for (int q = 0; q < 5; q++) begin
      gnt[q] = '0;
      found  = 1'b0;
      for (int i = 1; i < 6; i++) begin
        idx = {1'b0, last_r[q]} + 4'(i);
        if (idx > 4'd4) idx = idx - 4'd5;
        if (!found && req[q][idx[2:0]]) begin
          gnt[q] = idx[2:0];
          found  = 1'b1;
        end
      end
      v_o[q]    = |req[q];
      data_o[q] = head[gnt[q]];
    end
  end

  // Dequeue the input that won an output that transferred
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      deq[p] = 1'b0;
      for (int q = 0; q < 5; q++) begin
        if (xfer[q] && gnt[q] == 3'(p)) deq[p] = 1'b1;
      end
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < 5; p++) begin
      if (enq[p]) mem_r[p][wr_ptr_r[p]] <= data_i[p];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (enq[p]) wr_ptr_r[p] <= nxt(wr_ptr_r[p]);
        if (deq[p]) rd_ptr_r[p] <= nxt(rd_ptr_r[p]);
        unique case ({enq[p], deq[p]})
          2'b10:   cnt_r[p] <= cnt_r[p] + 1'b1;
          2'b01:   cnt_r[p] <= cnt_r[p] - 1'b1;
          default: cnt_r[p] <= cnt_r[p];
        endcase
      end
    end
  end

  // Round-robin pointers move only on a transfer
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      last_r <= '0;
    end else begin
      for (int q = 0; q < 5; q++) begin
        if (xfer[q]) last_r[q] <= gnt[q];
      end
    end
  end

`ifdef BSG_MESH_ROUTER_STATS_EN
  // Per-output transfer counters, wrapping at 2^32
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pkt_count_o <= '0;
    end else begin
      for (int q = 0; q < 5; q++) begin
        if (xfer[q]) pkt_count_o[q] <= pkt_count_o[q] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mesh_xy_router_node.sv
// Scoreboard bench for bsg_mesh_xy_router_node.
// Expected packets are queued per output and popped on each transfer.
module tb_bsg_mesh_xy_router_node;

  localparam int PW = 40;
  localparam int P = 0;
  localparam int W = 1;
  localparam int E = 2;
  localparam int N = 3;
  localparam int S = 4;

  logic clk_i = 1'b0;
  logic reset_i;
  logic [3:0] my_x_i;
  logic [3:0] my_y_i;
  logic [4:0] v_i;
  logic [4:0][PW-1:0] data_i;
  logic [4:0] ready_o;
  logic [4:0] v_o;
  logic [4:0][PW-1:0] data_o;
  logic [4:0] ready_i;
`ifdef BSG_MESH_ROUTER_STATS_EN
  logic [4:0][31:0] pkt_count_o;
`endif

  bsg_mesh_xy_router_node dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .my_x_i  (my_x_i),
    .my_y_i  (my_y_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .ready_i (ready_i)
`ifdef BSG_MESH_ROUTER_STATS_EN
    ,
    .pkt_count_o (pkt_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail = 0;
  logic [PW-1:0] exp_q [5][$];
  int out_log [$];
  logic [4:0] last_acc;
  logic [4:0] last_vo;
  logic [4:0] last_xfer;

  function automatic logic [PW-1:0] mk(
    logic [3:0] x, logic [3:0] y, logic [31:0] d);
    return {d, y, x};
  endfunction

  // One cycle: sample at negedge, score transfers, return after posedge
  task automatic tick();
    logic [PW-1:0] e;
    @(negedge clk_i);
    last_vo   = v_o;
    last_xfer = v_o & ready_i;
    last_acc  = v_i & ready_o;
    for (int q = 0; q < 5; q++) begin
      if (last_xfer[q]) begin
        out_log.push_back(q);
        n_assert++;
        if (exp_q[q].size() == 0) begin
          n_fail++;
          $display("FAIL sb_port%0d got %h want none", q, data_o[q]);
        end else begin
          e = exp_q[q].pop_front();
          if (data_o[q] !== e) begin
            n_fail++;
            $display("FAIL sb_port%0d got %h want %h", q, data_o[q], e);
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(int p, logic [PW-1:0] pkt);
    logic done;
    done = 1'b0;
    data_i[p] = pkt;
    v_i[p] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!done) begin
        tick();
        if (last_acc[p]) done = 1'b1;
      end
    end
    v_i[p] = 1'b0;
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout port%0d got 0 want 1", p);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    for (int q = 0; q < 5; q++) exp_q[q].delete();
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    #1;
    n_assert += 2;
    if (v_o !== 5'h00) begin
      n_fail++;
      $display("FAIL rst_vo got %h want 00", v_o);
    end
    if (ready_o !== 5'h1F) begin
      n_fail++;
      $display("FAIL rst_ready got %h want 1f", ready_o);
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    tick();
    n_assert += 2;
    if (last_vo !== 5'h00) begin
      n_fail++;
      $display("FAIL post_rst_vo got %h want 00", last_vo);
    end
    if (ready_o !== 5'h1F) begin
      n_fail++;
      $display("FAIL post_rst_ready got %h want 1f", ready_o);
    end
  endtask

  task automatic test_local();
    logic [PW-1:0] pkt;
    pkt = mk(4'd2, 4'd2, 32'hA5C3_0F1E);
    exp_q[P].push_back(pkt);
    send(P, pkt);
    n_assert++;
    if (last_vo[P] !== 1'b0) begin
      n_fail++;
      $display("FAIL local_latency got 1 want 0");
    end
    tick();
    n_assert += 2;
    if (last_xfer[P] !== 1'b1) begin
      n_fail++;
      $display("FAIL local_out got 0 want 1");
    end
    if (exp_q[P].size() != 0) begin
      n_fail++;
      $display("FAIL local_left got %0d want 0", exp_q[P].size());
    end
  endtask

  task automatic test_routes();
    int ord [4];
    logic [PW-1:0] pk [4];
    ord = '{E, W, N, S};
    pk[0] = mk(4'd3, 4'd0, 32'h11);
    pk[1] = mk(4'd1, 4'd5, 32'h22);
    pk[2] = mk(4'd2, 4'd0, 32'h33);
    pk[3] = mk(4'd2, 4'd4, 32'h44);
    out_log.delete();
    for (int i = 0; i < 4; i++) exp_q[ord[i]].push_back(pk[i]);
    for (int i = 0; i < 4; i++) send(W, pk[i]);
    for (int i = 0; i < 3; i++) tick();
    n_assert++;
    if (out_log.size() != 4) begin
      n_fail++;
      $display("FAIL route_count got %0d want 4", out_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_assert++;
        if (out_log[i] != ord[i]) begin
          n_fail++;
          $display("FAIL route_%0d got %0d want %0d",
                   i, out_log[i], ord[i]);
        end
      end
    end
  endtask

  task automatic test_rotation();
    int seq [5];
    int src [3];
    int it;
    int nx;
    src = '{W, E, N};
    seq = '{0, 0, 0, 0, 0};
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 3; k++) begin
        exp_q[P].push_back(mk(4'd2, 4'd2, 32'(src[k] * 256 + r)));
      end
    end
    it = 0;
    nx = 0;
    while (exp_q[P].size() != 0 && it < 40) begin
      for (int k = 0; k < 3; k++) begin
        v_i[src[k]] = (seq[src[k]] < 6);
        data_i[src[k]] =
          mk(4'd2, 4'd2, 32'(src[k] * 256 + seq[src[k]]));
      end
      tick();
      it++;
      if (last_xfer[P]) nx++;
      for (int k = 0; k < 3; k++) begin
        if (last_acc[src[k]]) seq[src[k]]++;
      end
    end
    v_i = '0;
    n_assert += 2;
    if (it != 19) begin
      n_fail++;
      $display("FAIL rot_cycles got %0d want 19", it);
    end
    if (nx != 18) begin
      n_fail++;
      $display("FAIL rot_xfers got %0d want 18", nx);
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] pk [3];
    for (int i = 0; i < 3; i++) begin
      pk[i] = mk(4'd3, 4'd2, 32'(32'hB00 + i));
      exp_q[E].push_back(pk[i]);
    end
    ready_i[E] = 1'b0;
    v_i[P] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_i[P] = pk[i];
      tick();
      n_assert++;
      if (last_acc[P] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_acc%0d got 0 want 1", i);
      end
    end
    data_i[P] = pk[2];
    n_assert += 2;
    if (ready_o[P] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full got 1 want 0");
    end
    if (v_o[E] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_vo got 0 want 1");
    end
    ready_i[E] = 1'b1;
    tick();
    n_assert += 2;
    if (last_acc[P] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_bypass got 1 want 0");
    end
    if (last_xfer[E] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_out0 got 0 want 1");
    end
    tick();
    n_assert += 2;
    if (last_acc[P] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_acc2 got 0 want 1");
    end
    if (last_xfer[E] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_out1 got 0 want 1");
    end
    v_i[P] = 1'b0;
    tick();
    n_assert += 2;
    if (last_xfer[E] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_out2 got 0 want 1");
    end
    if (exp_q[E].size() != 0) begin
      n_fail++;
      $display("FAIL bp_left got %0d want 0", exp_q[E].size());
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    ready_i = '0;
    send(W, mk(4'd2, 4'd2, 32'hDEAD));
    send(W, mk(4'd2, 4'd2, 32'hBEEF));
    n_assert++;
    if (v_o[P] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_buf got 0 want 1");
    end
    reset_i = 1'b0;
    #1;
    n_assert += 2;
    if (v_o !== 5'h00) begin
      n_fail++;
      $display("FAIL mid_vo got %h want 00", v_o);
    end
    if (ready_o !== 5'h1F) begin
      n_fail++;
      $display("FAIL mid_ready got %h want 1f", ready_o);
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    ready_i = 5'h1F;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (last_vo != 5'h00) seen++;
    end
    n_assert++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_stale got %0d want 0", seen);
    end
  endtask

`ifdef BSG_MESH_ROUTER_STATS_EN
  task automatic test_stats();
    logic [4:0][31:0] want;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q[S].push_back(mk(4'd2, 4'd3, 32'(32'h500 + i)));
      send(P, mk(4'd2, 4'd3, 32'(32'h500 + i)));
    end
    tick();
    tick();
    want = '0;
    want[S] = 32'd5;
    n_assert++;
    if (pkt_count_o !== want) begin
      n_fail++;
      $display("FAIL stats_cnt got %h want %h", pkt_count_o, want);
    end
    reset_i = 1'b0;
    #1;
    n_assert++;
    if (pkt_count_o !== '0) begin
      n_fail++;
      $display("FAIL stats_rst got %h want 0", pkt_count_o);
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
  endtask
`endif

  initial begin
    reset_i = 1'b0;
    my_x_i  = 4'd2;
    my_y_i  = 4'd2;
    v_i     = '0;
    data_i  = '0;
    ready_i = 5'h1F;
    test_reset();
    test_local();
    test_routes();
    test_rotation();
    test_backpressure();
    test_reset_mid();
`ifdef BSG_MESH_ROUTER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
